halut_decoder_feeder: RTL

Row buffer and sequencer directly upstream of the LUT decoder. It accepts encoded rows from the encoder: one prototype index per codebook, packed C×log2(K) bits per row. Rows are buffered in a small FIFO and streamed to the decoder one codebook per cycle, as a (c_addr, k_addr, decoder-enable) triple with c_addr counting 0..C-1. Rows with a queued successor are sent back-to-back with no bubble, so the decoder can accumulate and emit one FP32 result per C cycles.

---
 rtl/halut_decoder_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/halut_decoder_feeder.sv
// halut_decoder_feeder: row FIFO plus per-codebook sequencer feeding the LUT decoder.
// Each buffered row is streamed as (c_addr, k_addr) pairs, one codebook per cycle.
// The next queued row starts on the cycle after the previous row's last codebook,
// with no bubble in between.
// Optional build macro HALUT_DECODER_FEEDER_PERF_EN enables the 32-bit saturating
// performance counters. When it is undefined, the counter ports are tied to zero.
module halut_decoder_feeder #(
    parameter int unsigned K     = 16,
    parameter int unsigned C     = 32,
    parameter int unsigned Depth = 4,
    localparam int unsigned TreeDepth  = $clog2(K),
    localparam int unsigned CAddrWidth = $clog2(C),
    localparam int unsigned FillWidth  = $clog2(Depth) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      flush_i,
    input  logic                      row_valid_i,
    output logic                      row_ready_o,
    input  logic [C*TreeDepth-1:0]    row_k_i,
    output logic [CAddrWidth-1:0]     c_addr_o,
    output logic [TreeDepth-1:0]      k_addr_o,
    output logic                      decoder_o,
    output logic [FillWidth-1:0]      fill_o,
    output logic [31:0]               rows_streamed_o,
    output logic [31:0]               idle_cycles_o
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    // One row viewed as C codebook slots; slot c sits at bits [c*TreeDepth +: TreeDepth].
    typedef logic [C-1:0][TreeDepth-1:0] row_t;
    typedef enum logic {IDLE, STREAM} state_e;

    state_e                  state_q, state_d;
    logic [CAddrWidth-1:0]   c_cnt_q;
    row_t                    active_q;
    row_t [Depth-1:0]        mem_q;
    logic [PtrWidth-1:0]     wptr_q, rptr_q;
    logic [FillWidth-1:0]    fill_q;
    logic                    c_last, push, pop, fifo_nonempty;

    assign c_last        = (c_cnt_q == CAddrWidth'(C - 1));
    assign fifo_nonempty = (fill_q != '0);
    // Ready looks only at the held count, so a full FIFO refuses a push even if it pops now.
    assign row_ready_o   = (fill_q < FillWidth'(Depth)) && !flush_i;
    assign push          = row_valid_i && row_ready_o;
    assign pop           = !flush_i && fifo_nonempty && ((state_q == IDLE) || c_last);
    assign fill_o        = fill_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state: load a row when one is queued, otherwise drain back to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (fifo_nonempty) state_d = STREAM;
                STREAM:  if (c_last && !fifo_nonempty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: all derived from flops. k_addr is forced to zero outside STREAM.
    always_comb begin
        decoder_o = (state_q == STREAM);
        c_addr_o  = c_cnt_q;
        k_addr_o  = decoder_o ? active_q[c_cnt_q] : '0;
    end

    // Codebook counter: it advances while streaming and wraps to 0 after the last codebook.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  c_cnt_q <= '0;
        else if (flush_i)             c_cnt_q <= '0;
        else if (state_q == STREAM)   c_cnt_q <= c_last ? '0 : c_cnt_q + CAddrWidth'(1);
        else                          c_cnt_q <= '0;
    end

    // Active row register: it is loaded from the FIFO head on every pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)  active_q <= '0;
        else if (pop) active_q <= mem_q[rptr_q];
    end

    // FIFO storage holds data only; validity is tracked by the pointers and the fill count.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= row_k_i;
    end

    // FIFO pointers and fill count. A push and a pop in the same cycle leave the fill unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrWidth'(1);
            if (pop)  rptr_q <= rptr_q + PtrWidth'(1);
            fill_q <= fill_q + FillWidth'(push) - FillWidth'(pop);
        end
    end

`ifdef HALUT_DECODER_FEEDER_PERF_EN
    logic [31:0] rows_q, idle_q;

    // Performance counters: both saturate, and a flush clears them and suppresses the row increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rows_q <= '0;
            idle_q <= '0;
        end else if (flush_i) begin
            rows_q <= '0;
            idle_q <= '0;
        end else begin
            if ((state_q == STREAM) && c_last && (rows_q != '1)) rows_q <= rows_q + 32'd1;
            if ((state_q != STREAM) && (idle_q != '1))           idle_q <= idle_q + 32'd1;
        end
    end

    assign rows_streamed_o = rows_q;
    assign idle_cycles_o   = idle_q;
`else
    assign rows_streamed_o = '0;
    assign idle_cycles_o   = '0;
`endif

endmodule
